// File: rtl/word_red_r26_seq.sv
// Sequencer for the word-level Montgomery reducer: streams the low word with qH, then the upper
// word, then drains the reducer pipeline and returns its T output over a valid/ready handshake.
module word_red_r26_seq #(
    parameter int unsigned K      = 90,
    parameter int unsigned R      = 26,
    parameter int unsigned LAT    = 4,
    parameter int unsigned FF_OUT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K-1:0]   c_in,
    input  logic [R-1:0]   qh_in,
    output logic [K-1:0]   red_C,
    output logic [R-1:0]   red_qH,
    input  logic [K-R-1:0] red_T,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [K-R-1:0] t_out,
    output logic           busy
);

    localparam int unsigned DrainCyc = LAT + FF_OUT;
    localparam int unsigned CntW     = $clog2(DrainCyc + 1);

    if (DrainCyc == 0) begin : g_bad_drain
        $error("word_red_r26_seq: LAT+FF_OUT must be nonzero");
    end

    typedef enum logic [2:0] {StIdle, StLow, StHigh, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [K-R-1:0]  c_hi_q, c_hi_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [K-1:0]    red_c_q, red_c_d;
    logic [R-1:0]    red_qh_q, red_qh_d;
    logic [K-R-1:0]  t_q, t_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;

    // Reducer inputs are registered, so each word is loaded on the edge entering its state.
    always_comb begin
        state_d     = state_q;
        c_hi_d      = c_hi_q;
        cnt_d       = cnt_q;
        red_c_d     = '0;
        red_qh_d    = '0;
        t_d         = t_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    c_hi_d   = c_in[K-1:R];
                    red_c_d  = {{(K-R){1'b0}}, c_in[R-1:0]};
                    red_qh_d = qh_in;
                    state_d  = StLow;
                end
            end
            StLow: begin
                red_c_d = {c_hi_q, {R{1'b0}}};
                state_d = StHigh;
            end
            StHigh: begin
                cnt_d   = CntW'(DrainCyc);
                state_d = StDrain;
            end
            StDrain: begin
                if (cnt_q == CntW'(1)) begin
                    t_d         = red_T;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase

        in_ready_d = (state_d == StIdle);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            c_hi_q      <= '0;
            cnt_q       <= '0;
            red_c_q     <= '0;
            red_qh_q    <= '0;
            t_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_hi_q      <= c_hi_d;
            cnt_q       <= cnt_d;
            red_c_q     <= red_c_d;
            red_qh_q    <= red_qh_d;
            t_q         <= t_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign red_C     = red_c_q;
    assign red_qH    = red_qh_q;
    assign t_out     = t_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_word_red_r26_seq.sv
// Directed bench for word_red_r26_seq: default-parameter instance plus a LAT=1/FF_OUT=0 instance.
// red_T is driven by the bench with a known value only in the expected capture cycle.
module tb_word_red_r26_seq;

    localparam int K = 90;
    localparam int R = 26;

    localparam logic [K-1:0]   C1    = 90'h328b4fa42485e3a0a5d2f34;
    localparam logic [R-1:0]   Q1    = 26'h2000046;
    localparam logic [K-1:0]   C1_LO = 90'h25d2f34;
    localparam logic [K-1:0]   C1_HI = 90'h328b4fa42485e3a08000000;
    localparam logic [K-R-1:0] T1    = 64'hfe875f38e3940e83;
    localparam logic [K-1:0]   C2    = 90'h0123456789abcdef0123456;
    localparam logic [R-1:0]   Q2    = 26'h1555555;
    localparam logic [K-1:0]   C2_LO = 90'h0123456;
    localparam logic [K-1:0]   C2_HI = 90'h0123456789abcdef0000000;
    localparam logic [K-R-1:0] T2    = 64'h0f1e2d3c4b5a6978;
    localparam logic [K-R-1:0] T3    = 64'h1122334455667788;
    localparam logic [K-1:0]   CX    = 90'h3ffffffffffffffffffffff;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [K-1:0]   c_in = '0;
    logic [R-1:0]   qh_in = '0;
    logic [K-R-1:0] red_t;

    logic           in_ready, out_valid, busy;
    logic [K-1:0]   red_c;
    logic [R-1:0]   red_qh;
    logic [K-R-1:0] t_out;
    logic           in_ready2, out_valid2, busy2;
    logic [K-1:0]   red_c2;
    logic [R-1:0]   red_qh2;
    logic [K-R-1:0] t_out2;

    int unsigned    cyc = 0;
    int unsigned    cap0 = 32'hffffffff;
    int unsigned    cap1 = 32'hffffffff;
    logic [K-R-1:0] g0 = '0;
    logic [K-R-1:0] g1 = '0;
    int             n_vec = 0;
    int             n_bad = 0;
    int             ov_rises = 0;
    logic           ov_prev = 1'b0;

    word_red_r26_seq #(.K(K), .R(R), .LAT(4), .FF_OUT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .c_in(c_in),
        .qh_in(qh_in), .red_C(red_c), .red_qH(red_qh), .red_T(red_t), .out_valid(out_valid),
        .out_ready(out_ready), .t_out(t_out), .busy(busy)
    );

    word_red_r26_seq #(.K(K), .R(R), .LAT(1), .FF_OUT(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .c_in(c_in),
        .qh_in(qh_in), .red_C(red_c2), .red_qH(red_qh2), .red_T(red_t), .out_valid(out_valid2),
        .out_ready(out_ready), .t_out(t_out2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Any capture outside the expected cycle picks up a cycle-stamped filler value.
    assign red_t = (cyc == cap0) ? g0 : (cyc == cap1) ? g1 : {32'hc0de0000, cyc};

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ov_prev <= out_valid;
        if (out_valid && !ov_prev) ov_rises <= ov_rises + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [K-1:0] c;
        logic [R-1:0] qh;
        logic         ov;
        logic         bsy;
        logic         ir;
    } vec_t;

    vec_t nom[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic accept(input logic [K-1:0] c, input logic [R-1:0] q, output int unsigned a);
        chk("accept_ready", 128'(in_ready), 128'(1));
        c_in     = c;
        qh_in    = q;
        in_valid = 1'b1;
        a        = cyc;
        step();
        in_valid = 1'b0;
    endtask

    int unsigned a;
    int          r0;
    int          roffs[2];

    initial begin
        nom[0] = '{c: C1_LO, qh: Q1, ov: 1'b0, bsy: 1'b1, ir: 1'b0};
        nom[1] = '{c: C1_HI, qh: '0, ov: 1'b0, bsy: 1'b1, ir: 1'b0};
        for (int i = 2; i < 7; i++) nom[i] = '{c: '0, qh: '0, ov: 1'b0, bsy: 1'b1, ir: 1'b0};
        nom[7] = '{c: '0, qh: '0, ov: 1'b1, bsy: 1'b1, ir: 1'b0};
        roffs = '{4, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_red_c", 128'(red_c), 128'(0));
        chk("rst_red_qh", 128'(red_qh), 128'(0));
        chk("rst_t_out", 128'(t_out), 128'(0));
        rst = 1'b1;
        step();
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        chk("post_rst_busy", 128'(busy), 128'(0));

        // Nominal product with backpressure and ignored inputs while busy
        out_ready = 1'b0;
        r0 = ov_rises;
        cap0 = cyc + 7;
        g0 = T1;
        accept(C1, Q1, a);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("nom%0d_red_c", i + 1), 128'(red_c), 128'(nom[i].c));
            chk($sformatf("nom%0d_red_qh", i + 1), 128'(red_qh), 128'(nom[i].qh));
            chk($sformatf("nom%0d_out_valid", i + 1), 128'(out_valid), 128'(nom[i].ov));
            chk($sformatf("nom%0d_busy", i + 1), 128'(busy), 128'(nom[i].bsy));
            chk($sformatf("nom%0d_in_ready", i + 1), 128'(in_ready), 128'(nom[i].ir));
            if (i == 7) chk("nom_t_out", 128'(t_out), 128'(T1));
            in_valid = (i == 1 || i == 4);
            c_in     = CX;
            qh_in    = '1;
            if (i < 7) step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_t_out", 128'(t_out), 128'(T1));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_busy", 128'(busy), 128'(1));
            chk("bp_red_c", 128'(red_c), 128'(0));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("rel_out_valid", 128'(out_valid), 128'(0));
        chk("rel_in_ready", 128'(in_ready), 128'(1));
        chk("rel_busy", 128'(busy), 128'(0));
        chk("one_out_valid", 128'(ov_rises - r0), 128'(1));

        // Reset in the middle of an operation
        foreach (roffs[j]) begin
            cap0 = cyc + 7;
            g0 = T2;
            accept(C2, Q2, a);
            repeat (roffs[j] - 1) step();
            chk("midrst_pre_busy", 128'(busy), 128'(1));
            rst = 1'b0;
            #1;
            chk("midrst_red_c", 128'(red_c), 128'(0));
            chk("midrst_red_qh", 128'(red_qh), 128'(0));
            chk("midrst_out_valid", 128'(out_valid), 128'(0));
            chk("midrst_busy", 128'(busy), 128'(0));
            chk("midrst_t_out", 128'(t_out), 128'(0));
            @(posedge clk);
            #1;
            rst = 1'b1;
            r0 = ov_rises;
            repeat (12) step();
            chk("midrst_no_spurious", 128'(ov_rises - r0), 128'(0));
            chk("midrst_in_ready", 128'(in_ready), 128'(1));
        end

        // LAT=1, FF_OUT=0 instance
        out_ready = 1'b1;
        cap0 = cyc + 3;
        g0 = T3;
        accept(C1, Q1, a);
        chk("sw_low_red_c", 128'(red_c2), 128'(C1_LO));
        chk("sw_low_red_qh", 128'(red_qh2), 128'(Q1));
        step();
        chk("sw_high_red_c", 128'(red_c2), 128'(C1_HI));
        chk("sw_high_red_qh", 128'(red_qh2), 128'(0));
        step();
        chk("sw_drain_red_c", 128'(red_c2), 128'(0));
        chk("sw_drain_out_valid", 128'(out_valid2), 128'(0));
        chk("sw_drain_busy", 128'(busy2), 128'(1));
        step();
        chk("sw_out_valid", 128'(out_valid2), 128'(1));
        chk("sw_t_out", 128'(t_out2), 128'(T3));
        step();
        chk("sw_done_out_valid", 128'(out_valid2), 128'(0));
        chk("sw_done_in_ready", 128'(in_ready2), 128'(1));
        for (int i = 0; i < 20 && !in_ready; i++) step();
        chk("sw_idle", 128'(in_ready), 128'(1));

        // Back-to-back with in_valid and out_ready held high
        c_in     = C1;
        qh_in    = Q1;
        in_valid = 1'b1;
        a        = cyc;
        cap0     = a + 7;
        g0       = T1;
        cap1     = a + 16;
        g1       = T2;
        chk("b2b_ready", 128'(in_ready), 128'(1));
        step();
        c_in  = C2;
        qh_in = Q2;
        for (int k = 1; k <= 18; k++) begin
            chk($sformatf("b2b%0d_out_valid", k), 128'(out_valid), 128'(k == 8 || k == 17));
            chk($sformatf("b2b%0d_in_ready", k), 128'(in_ready), 128'(k == 9 || k == 18));
            if (k == 1) chk("b2b_low1", 128'(red_c), 128'(C1_LO));
            if (k == 9) chk("b2b_no_accept_in_done", 128'(red_c), 128'(0));
            if (k == 10) chk("b2b_low2", 128'(red_c), 128'(C2_LO));
            if (k == 10) chk("b2b_qh2", 128'(red_qh), 128'(Q2));
            if (k == 11) chk("b2b_high2", 128'(red_c), 128'(C2_HI));
            if (k == 8) chk("b2b_t1", 128'(t_out), 128'(T1));
            if (k == 17) chk("b2b_t2", 128'(t_out), 128'(T2));
            if (k == 17) in_valid = 1'b0;
            if (k < 18) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/word_red_r26_seq.md
# word_red_r26_seq

Sequencer that drives the word-level Montgomery reduction unit `word_red_r26` (radix 2^26) from a full-width product and collects its result. It accepts a K-bit product C and the R-bit quotient seed qH over a valid/ready handshake. It then streams the words in the order the reducer expects: low word with qH, then the shifted upper part, then zeros for the pipeline drain. It captures the reducer's T output and returns it over a second valid/ready handshake. It sits between the multiplier datapath and the `word_red_r26` instance. It processes one reduction at a time.

## Interface

Parameters:
- K, 90: product width in bits.
- R, 26: word width, which is also the width of qH.
- LAT, 4: latency of the `word_red_r26` pipeline in cycles.
- FF_OUT, 1: set to 1 when `word_red_r26` registers T; adds one capture cycle.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: a product is presented.
- in_ready, output, 1: the block can accept a product.
- c_in, input, K: product C.
- qh_in, input, R: quotient seed qH for this product.
- red_C, output, K: drives the C input of the reducer.
- red_qH, output, R: drives the qH input of the reducer.
- red_T, input, K-R: T output of the reducer.
- out_valid, output, 1: t_out holds a result.
- out_ready, input, 1: the consumer accepts t_out.
- t_out, output, K-R: reduced result.
- busy, output, 1: high in every state except IDLE.

## Operation

- All outputs are registered.
- Reset (rst=0) forces the following, asynchronously:
  - state = IDLE;
  - red_C = 0, red_qH = 0, t_out = 0;
  - out_valid = 0, busy = 0;
  - in_ready = 1 from the first cycle after reset is released.
- FSM states: IDLE, LOW, HIGH, DRAIN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch c_in and qh_in, then go to LOW.
- LOW (one cycle):
  - red_C = {(K-R)'b0, C[R-1:0]}.
  - red_qH = qH.
- HIGH (one cycle):
  - red_C = {C[K-1:R], R'b0}, i.e. the upper part left in place with the low R bits cleared.
  - red_qH = 0.
- DRAIN (LAT+FF_OUT cycles, counted by a down-counter):
  - red_C = 0, red_qH = 0.
  - At the rising edge that ends the last DRAIN cycle, register red_T into t_out and go to DONE.
- DONE:
  - out_valid = 1; t_out is stable.
  - On out_ready, clear out_valid and go to IDLE.
- While not in IDLE:
  - in_ready = 0.
  - in_valid is ignored, and c_in/qh_in are not sampled.
- Back-to-back operation:
  - No overlap between products.
  - A new product can be accepted in the cycle after the DONE handshake.
- Counter width is clog2(LAT+FF_OUT+1). LAT+FF_OUT=0 is illegal; guard it with a generate-time check.
- Reset in the middle of an operation:
  - The in-flight result is dropped and out_valid is not raised.
  - The reducer inputs return to 0 immediately.

## Timing

- A = the accept edge, where in_valid && in_ready are both sampled high.
- Cycle A+1: LOW word on red_C/red_qH.
- Cycle A+2: HIGH word on red_C/red_qH.
- Cycles A+3 through A+2+LAT+FF_OUT: zeros on red_C/red_qH.
- t_out is captured at the edge ending cycle A+2+LAT+FF_OUT.
- out_valid is asserted from cycle A+3+LAT+FF_OUT. With the defaults this is A+8.
- Throughput: one result per 4+LAT+FF_OUT cycles when out_ready is held high.
- out_ready low in DONE:
  - The block holds out_valid, t_out and busy indefinitely.
  - red_C and red_qH stay 0.
- in_valid asserted during the DONE handshake cycle is not accepted. in_ready rises the following cycle.

## Test plan

- Nominal vector:
  - Stimulus: c_in = 90'h328b4fa42485e3a0a5d2f34, qh_in = 26'h2000046.
  - Expect red_C = 90'h25d2f34 and red_qH = 26'h2000046 in cycle A+1.
  - Expect red_C = 90'h328b4fa42485e3a08000000 and red_qH = 0 in cycle A+2.
  - Expect zeros on both in cycles A+3 to A+7.
  - Expect out_valid in cycle A+8 with t_out = 64'hfe875f38e3940e83, using a real `word_red_r26` (K=90, Y=12, FF_OUT=1).
- Backpressure:
  - Stimulus: out_ready = 0 for 10 cycles after out_valid rises.
  - Expect t_out and out_valid held, in_ready = 0, and busy = 1.
  - Release out_ready. Expect out_valid to fall and in_ready = 1 in the next cycle.
- Input while busy:
  - Stimulus: in_valid pulsed with a different c_in in cycles A+2 and A+5.
  - Expect the pulses to be ignored, t_out to still equal 64'hfe875f38e3940e83, and exactly one out_valid assertion.
- Reset mid-drain:
  - Stimulus: drive rst low in cycle A+4.
  - Expect red_C = 0, out_valid = 0 and busy = 0 immediately (asynchronous).
  - After rst is released, expect no spurious out_valid and in_ready = 1.
- Back-to-back:
  - Stimulus: two products with out_ready tied high.
  - Expect the second accept edge at cycle A+9, the second out_valid at cycle A+17, and both results correct.
- Parameter sweep:
  - Stimulus: LAT = 1 and FF_OUT = 0, using a stub reducer.
  - Expect out_valid at cycle A+4, with the capture edge at the end of cycle A+3.
